// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - ALU command encodings and field widths for the ARM pipeline
package arm_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int SHIFT_OP_W = 12;
  localparam int SIMM_W     = 24;
  localparam int STATUS_W   = 4;
  localparam int EXE_CMD_W  = 4;

  // Several mnemonics share an ALU operation (CMP is SUB, TST is AND, LDR/STR are ADD).
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MVN = 4'b1001;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_AND = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_EOR = 4'b1000;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_CMP = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_TST = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_LDR = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_STR = 4'b0010;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - flop bank with sync reset, clear (priority) and load enable
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID->EXE pipeline register with freeze, flush and bubble counter
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic [WIDTH-1:0]      pc_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic                  imm_in,
  input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
  input  logic [WIDTH-1:0]      val_rn_in,
  input  logic [WIDTH-1:0]      val_rm_in,
  input  logic [SHIFT_OP_W-1:0] shift_op_in,
  input  logic [SIMM_W-1:0]     simm24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [STATUS_W-1:0]   status_in,
  output logic [WIDTH-1:0]      pc_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic                  imm_out,
  output logic [EXE_CMD_W-1:0]  exe_cmd_out,
  output logic [WIDTH-1:0]      val_rn_out,
  output logic [WIDTH-1:0]      val_rm_out,
  output logic [SHIFT_OP_W-1:0] shift_op_out,
  output logic [SIMM_W-1:0]     simm24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [STATUS_W-1:0]   status_out,
  output logic                  valid_out,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int CTRL_W = 7 + EXE_CMD_W;
  localparam int DATA_W = 3 * WIDTH + SHIFT_OP_W + SIMM_W + STATUS_W;
  localparam int REGS_W = 3 * REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              load_en;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [REGS_W-1:0] regs_q;

  assign load_en = ~freeze;

  // valid rides with the control group: a constant 1 is loaded, flush clears it, freeze holds it.
  pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (load_en),
    .d   ({1'b1, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in}),
    .q   (ctrl_q)
  );

  pipe_reg #(.W(DATA_W)) u_data (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (load_en),
    .d   ({pc_in, val_rn_in, val_rm_in, shift_op_in, simm24_in, status_in}),
    .q   (data_q)
  );

  pipe_reg #(.W(REGS_W)) u_regs (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (load_en),
    .d   ({dest_in, src1_in, src2_in}),
    .q   (regs_q)
  );

  assign {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
          exe_cmd_out} = ctrl_q;
  assign {pc_out, val_rn_out, val_rm_out, shift_op_out, simm24_out, status_out} = data_q;
  assign {dest_out, src1_out, src2_out} = regs_q;

  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Both flush and stall push a bubble past EXE; the counter sticks at its maximum.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((flush || freeze) && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - self-checking bench for id_exe_reg against a behavioural model
module tb_id_exe_reg;

  localparam int VW = 158;

  logic clk = 1'b0;
  logic rst, flush, freeze;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0] exe_cmd_in, dest_in, src1_in, src2_in, status_in;
  logic [11:0] shift_op_in;
  logic [23:0] simm24_in;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out;
  logic [3:0] exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic [11:0] shift_op_out;
  logic [23:0] simm24_out;
  logic [15:0] bubble_cnt;

  logic [31:0] s_pc_out, s_val_rn_out, s_val_rm_out;
  logic s_wb_en_out, s_mem_r_en_out, s_mem_w_en_out, s_b_out, s_s_out, s_imm_out, s_valid_out;
  logic [3:0] s_exe_cmd_out, s_dest_out, s_src1_out, s_src2_out, s_status_out;
  logic [11:0] s_shift_op_out;
  logic [23:0] s_simm24_out;
  logic [1:0] s_bubble_cnt;

  always #5 clk = ~clk;

  id_exe_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_op_in(shift_op_in),
    .simm24_in(simm24_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .status_in(status_in),
    .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .imm_out(imm_out),
    .exe_cmd_out(exe_cmd_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_op_out(shift_op_out), .simm24_out(simm24_out), .dest_out(dest_out),
    .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
    .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

  id_exe_reg #(.WIDTH(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_op_in(shift_op_in),
    .simm24_in(simm24_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .status_in(status_in),
    .pc_out(s_pc_out), .wb_en_out(s_wb_en_out), .mem_r_en_out(s_mem_r_en_out),
    .mem_w_en_out(s_mem_w_en_out), .b_out(s_b_out), .s_out(s_s_out), .imm_out(s_imm_out),
    .exe_cmd_out(s_exe_cmd_out), .val_rn_out(s_val_rn_out), .val_rm_out(s_val_rm_out),
    .shift_op_out(s_shift_op_out), .simm24_out(s_simm24_out), .dest_out(s_dest_out),
    .src1_out(s_src1_out), .src2_out(s_src2_out), .status_out(s_status_out),
    .valid_out(s_valid_out), .bubble_cnt(s_bubble_cnt)
  );

  logic [VW-1:0] in_vec, out_vec, s_out_vec;
  assign in_vec = {pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
                   val_rn_in, val_rm_in, shift_op_in, simm24_in, dest_in, src1_in, src2_in,
                   status_in};
  assign out_vec = {pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
                    exe_cmd_out, val_rn_out, val_rm_out, shift_op_out, simm24_out, dest_out,
                    src1_out, src2_out, status_out};
  assign s_out_vec = {s_pc_out, s_wb_en_out, s_mem_r_en_out, s_mem_w_en_out, s_b_out, s_s_out,
                      s_imm_out, s_exe_cmd_out, s_val_rn_out, s_val_rm_out, s_shift_op_out,
                      s_simm24_out, s_dest_out, s_src1_out, s_src2_out, s_status_out};

  int checks = 0;
  int failures = 0;

  logic [VW-1:0] exp_vec;
  logic exp_valid;
  int exp_cnt, exp_cnt_s;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("fields", out_vec, exp_vec);
    chk("valid", VW'(valid_out), VW'(exp_valid));
    chk("bubble_cnt", VW'(bubble_cnt), VW'(exp_cnt));
    chk("s_fields", s_out_vec, exp_vec);
    chk("s_valid", VW'(s_valid_out), VW'(exp_valid));
    chk("s_bubble_cnt", VW'(s_bubble_cnt), VW'(exp_cnt_s));
  endtask

  // Model: the entry is a snapshot of the inputs; bubbles are counted as plain saturating integers.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_vec = '0; exp_valid = 1'b0; exp_cnt = 0; exp_cnt_s = 0;
    end else begin
      if (flush || freeze) begin
        exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
        exp_cnt_s = (exp_cnt_s < 3) ? exp_cnt_s + 1 : 3;
      end
      if (flush) begin
        exp_vec = '0; exp_valid = 1'b0;
      end else if (!freeze) begin
        exp_vec = in_vec; exp_valid = 1'b1;
      end
    end
    #1;
    check_model();
  endtask

  task automatic rand_in();
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom); src1_in = 4'($urandom);
    src2_in = 4'($urandom); status_in = 4'($urandom);
    shift_op_in = 12'($urandom); simm24_in = 24'($urandom);
  endtask

  task automatic zero_in();
    pc_in = '0; val_rn_in = '0; val_rm_in = '0;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = '0;
    exe_cmd_in = '0; dest_in = '0; src1_in = '0; src2_in = '0; status_in = '0;
    shift_op_in = '0; simm24_in = '0;
  endtask

  int sat_exp [6];

  initial begin
    exp_vec = '0; exp_valid = 1'b0; exp_cnt = 0; exp_cnt_s = 0;
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    rand_in();
    #1;

    rand_in(); flush = 1'b1; freeze = 1'b1;
    step();
    rand_in();
    step();
    chk("rst_out_zero", out_vec, '0);
    chk("rst_valid", VW'(valid_out), '0);
    chk("rst_cnt", VW'(bubble_cnt), '0);

    rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    zero_in();
    pc_in = 32'h10; val_rn_in = 32'hDEADBEEF; shift_op_in = 12'h4FF; wb_en_in = 1'b1;
    step();
    chk("load_pc", VW'(pc_out), VW'(32'h10));
    chk("load_rn", VW'(val_rn_out), VW'(32'hDEADBEEF));
    chk("load_shift", VW'(shift_op_out), VW'(12'h4FF));
    chk("load_wb", VW'(wb_en_out), VW'(1'b1));
    chk("load_valid", VW'(valid_out), VW'(1'b1));

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h20 + i; val_rn_in = 32'h12345678 ^ i;
      step();
    end
    chk("frz_pc", VW'(pc_out), VW'(32'h10));
    chk("frz_rn", VW'(val_rn_out), VW'(32'hDEADBEEF));
    chk("frz_valid", VW'(valid_out), VW'(1'b1));
    chk("frz_cnt", VW'(bubble_cnt), VW'(3));

    flush = 1'b1;
    step();
    chk("flush_out", out_vec, '0);
    chk("flush_valid", VW'(valid_out), '0);
    chk("flush_cnt", VW'(bubble_cnt), VW'(4));

    flush = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; freeze = 1'b1;
    sat_exp = '{1, 2, 3, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      rand_in();
      step();
      chk($sformatf("sat_cnt%0d", i), VW'(s_bubble_cnt), VW'(sat_exp[i]));
    end

    freeze = 1'b0; rand_in();
    step();
    freeze = 1'b1; rand_in();
    step();
    chk("pre_rst_valid", VW'(valid_out), VW'(1'b1));
    rst = 1'b1; rand_in();
    step();
    chk("mid_rst_out", out_vec, '0);
    chk("mid_rst_valid", VW'(valid_out), '0);
    rst = 1'b0; freeze = 1'b0; rand_in();
    step();
    chk("post_rst_load", out_vec, in_vec);
    chk("post_rst_valid", VW'(valid_out), VW'(1'b1));

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 5) == 0);
      freeze = ($urandom_range(0, 2) == 0);
      rand_in();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
